// File: rtl/multiplier_man_pkg.sv
// Shared widths and stage record for the shift-add multiply-accumulate pipeline.
// Widths follow the divider: N = quotient width, M = divisor/remainder width.
package multiplier_man_pkg;

  localparam int MM_N      = 5;
  localparam int MM_M      = 3;
  localparam int MM_PROD_W = MM_N + MM_M;

  typedef struct packed {
    logic                 en;
    logic [MM_PROD_W-1:0] acc;
    logic [MM_N-1:0]      mcand;
    logic [MM_M-1:0]      mplier;
  } stage_t;

endpackage

// File: rtl/multiplier_man_if.sv
// Operand/result bundle of multiplier_man; master drives operands, slave returns product.
// No backpressure: the consumer must sample product on result_ready.
interface multiplier_man_if #(
  parameter int N = 5,
  parameter int M = 3
);

  logic           data_enable;
  logic [N-1:0]   multiplicand;
  logic [M-1:0]   multiplier;
  logic [M-1:0]   addend;
  logic           result_ready;
  logic [N+M-1:0] product;

  modport master (
    output data_enable, multiplicand, multiplier, addend,
    input  result_ready, product
  );

  modport slave (
    input  data_enable, multiplicand, multiplier, addend,
    output result_ready, product
  );

endinterface

// File: rtl/multiplier_man_cell.sv
// One partial-product stage: adds (multiplicand << STAGE) when multiplier bit STAGE is set.
// Latency 1 clock; no backpressure, enable always advances, data holds when enable is low.
module multiplier_cell
  import multiplier_man_pkg::*;
#(
  parameter int STAGE = 0,
  parameter int N     = MM_N,
  parameter int M     = MM_M
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   prev_en,
  input  stage_t prev_stage,
  output logic   en,
  output stage_t stage
);

  localparam int PW = N + M;

  logic [N-1:0]  mcand;
  logic [M-1:0]  mplier;
  logic [PW-1:0] pp;
  stage_t        stage_q;

  assign mcand  = prev_stage.mcand;
  assign mplier = prev_stage.mplier;
  assign pp     = mplier[STAGE] ? (PW'(mcand) << STAGE) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      // The enable bit moves every cycle so bubbles travel as zeros.
      stage_q.en <= prev_stage.en;
      if (prev_en) begin
        stage_q.acc    <= prev_stage.acc + pp;
        stage_q.mcand  <= mcand;
        stage_q.mplier <= mplier;
      end
    end
  end

  assign stage = stage_q;
  assign en    = stage_q.en;

endmodule

// File: rtl/multiplier_man.sv
// Pipelined shift-add MAC, product = multiplicand*multiplier (+addend with MULTIPLIER_MAN_ADDEND_EN).
// Latency M clocks, one operand set per clock, no backpressure; outputs registered.
module multiplier_man
  import multiplier_man_pkg::*;
#(
  parameter int N = MM_N,
  parameter int M = MM_M
) (
  input  logic             clk,
  input  logic             rst_n,
  multiplier_man_if.slave  bus
);

  stage_t in_stage;
  stage_t st [M];
  logic   en_chain [M];

  always_comb begin
    in_stage        = '0;
    in_stage.en     = bus.data_enable;
    in_stage.mcand  = bus.multiplicand;
    in_stage.mplier = bus.multiplier;
`ifdef MULTIPLIER_MAN_ADDEND_EN
    // Seeding the accumulator with the addend keeps the add inside stage 0.
    in_stage.acc    = MM_PROD_W'(bus.addend);
`endif
  end

  for (genvar i = 0; i < M; i++) begin : g_stage
    if (i == 0) begin : g_first
      multiplier_cell #(.STAGE(i), .N(N), .M(M)) u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .prev_en    (bus.data_enable),
        .prev_stage (in_stage),
        .en         (en_chain[i]),
        .stage      (st[i])
      );
    end else begin : g_next
      multiplier_cell #(.STAGE(i), .N(N), .M(M)) u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .prev_en    (en_chain[i-1]),
        .prev_stage (st[i-1]),
        .en         (en_chain[i]),
        .stage      (st[i])
      );
    end
  end

  assign bus.result_ready = en_chain[M-1];
  assign bus.product      = st[M-1].acc;

endmodule

// File: tb/tb_multiplier_man.sv
// Randomized bench for multiplier_man against an arithmetic reference with issue-time queue.
// Covers directed cases, bubbles, mid-flight reset and the divider round trip.
module tb_multiplier_man;

  localparam int N = 5;
  localparam int M = 3;

`ifdef MULTIPLIER_MAN_ADDEND_EN
  localparam bit ADDEND_ON = 1'b1;
`else
  localparam bit ADDEND_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multiplier_man_if #(.N(N), .M(M)) bus ();

  multiplier_man #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int due;
    int val;
    int dividend;
    int rem;
    bit rt;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   held     = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic observe();
    exp_t e;
    bit   exp_rdy;
    exp_rdy = (q.size() > 0) && (q[0].due == cyc);
    check("result_ready", 32'(bus.result_ready), 32'(exp_rdy));
    if (exp_rdy) begin
      e = q.pop_front();
      check("product", 32'(bus.product), e.val);
      held = e.val;
      if (e.rt)
        check("roundtrip", 32'(bus.product) + (ADDEND_ON ? 0 : e.rem), e.dividend);
    end else begin
      check("product_hold", 32'(bus.product), held);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive_cycle(input bit en, input int a, input int b, input int c,
                             input bit rt = 1'b0, input int dividend = 0, input int rem = 0);
    exp_t e;
    bus.data_enable  = en;
    bus.multiplicand = a[N-1:0];
    bus.multiplier   = b[M-1:0];
    bus.addend       = c[M-1:0];
    @(posedge clk);
    cyc++;
    if (en) begin
      e.due      = cyc + M - 1;
      e.val      = a * b + (ADDEND_ON ? c : 0);
      e.dividend = dividend;
      e.rem      = rem;
      e.rt       = rt;
      q.push_back(e);
    end
    @(negedge clk);
    observe();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset_ready", 32'(bus.result_ready), 0);
    check("reset_product", 32'(bus.product), 0);
    q.delete();
    held = 0;
    bus.data_enable = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    observe();
  endtask

  initial begin
    int dv, ds;
    rst_n            = 1'b0;
    bus.data_enable  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.addend       = '0;
    repeat (2) @(negedge clk);
    check("init_ready", 32'(bus.result_ready), 0);
    check("init_product", 32'(bus.product), 0);
    rst_n = 1'b1;

    drive_cycle(1'b1, 9, 3, 2);
    idle(4);
    drive_cycle(1'b1, 31, 7, 6);
    idle(4);

    drive_cycle(1'b1, 1, 1, 0);
    drive_cycle(1'b1, 2, 3, 1);
    drive_cycle(1'b1, 0, 5, 4);
    drive_cycle(1'b1, 31, 0, 0);
    idle(5);

    drive_cycle(1'b1, 5, 2, 1);
    drive_cycle(1'b0, 7, 7, 7);
    drive_cycle(1'b1, 3, 3, 0);
    idle(4);

    drive_cycle(1'b1, 7, 7, 7);
    drive_cycle(1'b1, 3, 2, 1);
    pulse_reset();
    idle(5);

    for (int k = 0; k < 300; k++)
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                  $urandom_range(0, 7), $urandom_range(0, 7));
    idle(4);

    for (int k = 0; k < 200; k++) begin
      dv = $urandom_range(0, 31);
      ds = $urandom_range(1, 7);
      drive_cycle(1'b1, dv / ds, ds, dv % ds, 1'b1, dv, dv % ds);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(5);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
